multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the 16-bit CPU. It replaces single-cycle decode with a registered state machine that steps each instruction through fetch, decode, execute, memory and write-back. It also arbitrates the single shared instruction/data memory port through a ready handshake, and detects memory timeouts and illegal opcodes. It sits between the instruction register (IR) and the datapath mux/enable inputs.

## Interface
- MEM_TIMEOUT, 15: maximum wait cycles in a memory state before a bus fault; legal range 1..255.
- Clock  in  1  system clock; all state changes on the rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- OPCODE  in  3  IR[15:13]; valid from DECODE onward.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completed the current read or write this cycle.
- MemRead, MemWrite  out  1  memory strobes; held until MemReady.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite, PCWrite  out  1  IR and PC load enables.
- PCSource  out  1  PC input select: 0 = ALU result, 1 = ALUOut (branch target).
- RegDst, RegWrite, MemToReg  out  1  register-file controls.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B select: 00 = rt, 01 = const 2, 10 = sign-extended immediate, 11 = shifted immediate.
- ALUOp  out  2  ALU operation class: 00 = add, 01 = subtract, 10 = funct, 11 = immediate op.
- IllegalOp  out  1  one-cycle pulse on an undefined opcode.
- BusError  out  1  sticky memory-timeout fault flag.
- InstrRetired  out  16  count of completed instructions; wraps.

## Operation
- Opcodes:
  - 111 = R-format
  - 011 = ADDI
  - 100 = SLTI
  - 101 = LW
  - 110 = SW
  - 010 = BNE
  - 000 and 001 are illegal.
- States: FETCH, DECODE, EXEC, MEM, WB, FAULT.
- OPCODE is registered in DECODE. Later states use only the registered copy.
- Signal defaults: every output not listed for a state is 0.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - On MemReady: IRWrite=1, PCWrite=1, PCSource=0, and the FSM moves to DECODE.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Illegal opcode: IllegalOp=1 and the FSM returns to FETCH; the instruction is not counted. Legal opcode: the FSM moves to EXEC.
- EXEC, by opcode:
  - R-format: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next WB.
  - ADDI/SLTI: ALUSrcA=1, ALUSrcB=10, ALUOp=11; next WB.
  - LW/SW: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEM.
  - BNE: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=1, PCWrite=!Zero; next FETCH; the instruction retires.
- MEM:
  - Drives IorD=1, with MemRead=1 for LW or MemWrite=1 for SW.
  - On MemReady, LW moves to WB; SW moves to FETCH and retires.
- WB:
  - Drives RegWrite=1.
  - R-format: RegDst=1. LW: MemToReg=1.
  - Next FETCH; the instruction retires.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle the FSM is in FETCH or MEM with MemReady=0.
  - If MemReady=0 while the counter equals MEM_TIMEOUT, the FSM enters FAULT on the next edge.
- FAULT: all strobes 0, BusError=1. The only exit is reset.
- MemReady arriving on the same cycle the counter reaches MEM_TIMEOUT counts as success; MemReady wins.
- InstrRetired increments by 1 on the final cycle of each legal instruction and wraps from 0xFFFF to 0x0000.

## Timing
- Outputs are Moore/Mealy-on-state: combinational from the current state, registered opcode, Zero and MemReady. No output depends on the unregistered OPCODE except IllegalOp in DECODE.
- Cycles per instruction with zero memory wait:
  - BNE: 3
  - R-format, ADDI, SLTI, SW: 4
  - LW: 5
- Each memory wait cycle adds 1 cycle in FETCH or MEM.
- Reset:
  - Asserting ResetN=0 immediately forces state FETCH, wait counter 0, InstrRetired 0, BusError 0, registered opcode 000.
  - Every output is 0 while ResetN=0, including MemRead.
  - The first FETCH strobe appears in the first cycle after release.
  - Reset mid-instruction abandons the instruction; a pending memory access is dropped.

## Structure
- Shared package cpu16_pkg holds:
  - opcode constants
  - the state enum
  - ALUOp encodings and ALUSrcB encodings
- The existing combinational control unit is expected to import the same opcode constants.
- One sub-module, mem_wait_timer, contains the wait counter and timeout compare.
  - Inputs: Clock, ResetN, clear, waiting.
  - Output: expired.

## Test plan
- Reset release, then R-format (111) with MemReady tied 1: states FETCH, DECODE, EXEC, WB over 4 cycles; RegWrite=1 and RegDst=1 in cycle 4; InstrRetired=1.
- LW (101) with 2 wait cycles in MEM: 7 cycles total; MemToReg=1 and RegWrite=1 in WB; IorD=1 throughout MEM.
- BNE (010), run once with Zero=1 and once with Zero=0: PCWrite=0 on the first run and 1 on the second, with PCSource=1; 3 cycles each.
- Opcode 001: IllegalOp pulses for 1 cycle in DECODE; the FSM returns to FETCH; InstrRetired is unchanged.
- MEM_TIMEOUT=3 and MemReady held 0 in FETCH: FAULT is entered after 4 wait cycles; BusError stays 1 and all strobes stay 0 until ResetN=0.
- ResetN pulsed low during MEM of an SW: MemWrite drops immediately; after release the FSM is in FETCH with InstrRetired=0.

Source files
------------

// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit CPU control path: opcodes, sequencer
// states and the ALU operand/operation select encodings.
package cpu16_pkg;

  localparam logic [2:0] OP_RTYPE = 3'b111;
  localparam logic [2:0] OP_ADDI  = 3'b011;
  localparam logic [2:0] OP_SLTI  = 3'b100;
  localparam logic [2:0] OP_LW    = 3'b101;
  localparam logic [2:0] OP_SW    = 3'b110;
  localparam logic [2:0] OP_BNE   = 3'b010;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_CONST2  = 2'b01;
  localparam logic [1:0] SRCB_SIGNEXT = 2'b10;
  localparam logic [1:0] SRCB_SHIFTED = 2'b11;

  function automatic logic is_legal_op(input logic [2:0] op);
    logic legal;
    case (op)
      3'b000:  legal = 1'b0;
      3'b001:  legal = 1'b0;
      default: legal = 1'b1;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting on the shared memory port and flags
// the cycle on which a further wait would exceed the allowed budget.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic Clock,
  input  logic ResetN,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: cleared whenever the port is not stalled, saturating otherwise.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (waiting && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Wait counter register.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = waiting && (count_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, handshakes the shared memory port and traps timeouts.
module multicycle_control
  import cpu16_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic [2:0]  OPCODE,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSource,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        IllegalOp,
  output logic        BusError,
  output logic [15:0] InstrRetired
);

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] retired_q, retired_d;
  logic        bus_err_q, bus_err_d;
  logic        retire_s;
  logic        waiting_s;
  logic        expired_s;
  state_e      out_state_s;

  assign waiting_s = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !MemReady;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .Clock   (Clock),
    .ResetN  (ResetN),
    .clear   (!waiting_s),
    .waiting (waiting_s),
    .expired (expired_s)
  );

  // Next-state, opcode capture and retirement logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    retire_s  = 1'b0;
    bus_err_d = bus_err_q;
    case (state_q)
      ST_FETCH: begin
        if (MemReady) begin
          state_d = ST_DECODE;
        end else if (expired_s) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        op_d = OPCODE;
        if (is_legal_op(OPCODE)) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_LW, OP_SW: state_d = ST_MEM;
          OP_BNE: begin
            state_d  = ST_FETCH;
            retire_s = 1'b1;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (MemReady) begin
          if (op_q == OP_LW) begin
            state_d = ST_WB;
          end else begin
            state_d  = ST_FETCH;
            retire_s = 1'b1;
          end
        end else if (expired_s) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        state_d  = ST_FETCH;
        retire_s = 1'b1;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FETCH;
    endcase
    if (state_d == ST_FAULT) begin
      bus_err_d = 1'b1;
    end else begin
      bus_err_d = bus_err_q;
    end
    retired_d = retire_s ? (retired_q + 16'd1) : retired_q;
  end

  // Sequencer state registers.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= ST_FETCH;
      op_q      <= 3'b000;
      retired_q <= 16'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
      bus_err_q <= bus_err_d;
    end
  end

  // While reset is held, decode as FAULT so that every strobe reads 0.
  assign out_state_s = ResetN ? state_q : ST_FAULT;

  // Datapath control decode from the current state.
  always_comb begin
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSource  = 1'b0;
    RegDst    = 1'b0;
    RegWrite  = 1'b0;
    MemToReg  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RT;
    ALUOp     = ALUOP_ADD;
    IllegalOp = 1'b0;
    case (out_state_s)
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_CONST2;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      ST_DECODE: begin
        ALUSrcB   = SRCB_SHIFTED;
        IllegalOp = !is_legal_op(OPCODE);
      end
      ST_EXEC: begin
        ALUSrcA = 1'b1;
        case (op_q)
          OP_RTYPE: begin
            ALUSrcB = SRCB_RT;
            ALUOp   = ALUOP_FUNCT;
          end
          OP_ADDI, OP_SLTI: begin
            ALUSrcB = SRCB_SIGNEXT;
            ALUOp   = ALUOP_IMM;
          end
          OP_LW, OP_SW: begin
            ALUSrcB = SRCB_SIGNEXT;
            ALUOp   = ALUOP_ADD;
          end
          OP_BNE: begin
            ALUSrcB  = SRCB_RT;
            ALUOp    = ALUOP_SUB;
            PCSource = 1'b1;
            PCWrite  = !Zero;
          end
          default: ALUSrcA = 1'b1;
        endcase
      end
      ST_MEM: begin
        IorD     = 1'b1;
        MemRead  = (op_q == OP_LW);
        MemWrite = (op_q == OP_SW);
      end
      ST_WB: begin
        RegWrite = 1'b1;
        RegDst   = (op_q == OP_RTYPE);
        MemToReg = (op_q == OP_LW);
      end
      default: IllegalOp = 1'b0;
    endcase
  end

  assign BusError     = bus_err_q;
  assign InstrRetired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control with a queue-based scoreboard.
module tb_multicycle_control;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic [2:0]  OPCODE;
  logic        Zero;
  logic        MemReady;
  logic        MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource;
  logic        RegDst, RegWrite, MemToReg, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp;
  logic        IllegalOp, BusError;
  logic [15:0] InstrRetired;

  typedef struct {
    string       tag;
    logic [15:0] ctl;
    logic [15:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  // ctl packing: MemRead MemWrite IorD IRWrite PCWrite PCSource RegDst RegWrite
  //              MemToReg ALUSrcA ALUSrcB[1:0] ALUOp[1:0] IllegalOp BusError
  localparam logic [15:0] C_RST     = 16'h0000;
  localparam logic [15:0] C_FWAIT   = 16'h8010;
  localparam logic [15:0] C_FRDY    = 16'h9810;
  localparam logic [15:0] C_DEC     = 16'h0030;
  localparam logic [15:0] C_DEC_ILL = 16'h0032;
  localparam logic [15:0] C_EX_R    = 16'h0048;
  localparam logic [15:0] C_EX_I    = 16'h006C;
  localparam logic [15:0] C_EX_M    = 16'h0060;
  localparam logic [15:0] C_EX_BZ   = 16'h0444;
  localparam logic [15:0] C_EX_BNZ  = 16'h0C44;
  localparam logic [15:0] C_MEM_LW  = 16'hA000;
  localparam logic [15:0] C_MEM_SW  = 16'h6000;
  localparam logic [15:0] C_WB_R    = 16'h0300;
  localparam logic [15:0] C_WB_I    = 16'h0100;
  localparam logic [15:0] C_WB_LW   = 16'h0180;
  localparam logic [15:0] C_FAULT   = 16'h0001;
  localparam logic [2:0]  X         = 3'b000;

  logic [15:0] ctl_act;
  assign ctl_act = {MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource, RegDst, RegWrite,
                    MemToReg, ALUSrcA, ALUSrcB, ALUOp, IllegalOp, BusError};

  always #5 Clock = ~Clock;

  multicycle_control #(.MEM_TIMEOUT(3)) dut (
    .Clock(Clock), .ResetN(ResetN), .OPCODE(OPCODE), .Zero(Zero), .MemReady(MemReady),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSource(PCSource), .RegDst(RegDst), .RegWrite(RegWrite),
    .MemToReg(MemToReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .IllegalOp(IllegalOp), .BusError(BusError), .InstrRetired(InstrRetired)
  );

  // Monitor: checks the expected response for the current cycle mid-period.
  always @(negedge Clock) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (ctl_act !== e.ctl) begin
        tests_failed++;
        $display("FAIL %s ctl: got %h expected %h", e.tag, ctl_act, e.ctl);
      end
      tests_run++;
      if (InstrRetired !== e.ret) begin
        tests_failed++;
        $display("FAIL %s retired: got %0d expected %0d", e.tag, InstrRetired, e.ret);
      end
    end
  end

  task automatic step(input logic [2:0] op, input logic z, input logic rdy,
                      input logic [15:0] ctl, input logic [15:0] ret, input string tag);
    exp_t e;
    OPCODE   = op;
    Zero     = z;
    MemReady = rdy;
    e.tag = tag;
    e.ctl = ctl;
    e.ret = ret;
    exp_q.push_back(e);
    @(posedge Clock);
    #1;
  endtask

  task automatic reset_cycle(input string tag);
    ResetN = 1'b0;
    step(X, 1'b0, 1'b1, C_RST, 16'd0, tag);
    ResetN = 1'b1;
  endtask

  initial begin
    ResetN   = 1'b0;
    OPCODE   = 3'b111;
    Zero     = 1'b0;
    MemReady = 1'b1;
    @(posedge Clock);
    #1;
    reset_cycle("reset");

    // R-format, no waits
    step(X,      1'b0, 1'b1, C_FRDY,   16'd0, "r_fetch");
    step(3'b111, 1'b0, 1'b1, C_DEC,    16'd0, "r_dec");
    step(X,      1'b0, 1'b1, C_EX_R,   16'd0, "r_exec");
    step(X,      1'b0, 1'b1, C_WB_R,   16'd0, "r_wb");
    // ADDI and SLTI
    step(X,      1'b0, 1'b1, C_FRDY,   16'd1, "addi_fetch");
    step(3'b011, 1'b0, 1'b1, C_DEC,    16'd1, "addi_dec");
    step(X,      1'b0, 1'b1, C_EX_I,   16'd1, "addi_exec");
    step(X,      1'b0, 1'b1, C_WB_I,   16'd1, "addi_wb");
    step(X,      1'b0, 1'b1, C_FRDY,   16'd2, "slti_fetch");
    step(3'b100, 1'b0, 1'b1, C_DEC,    16'd2, "slti_dec");
    step(X,      1'b0, 1'b1, C_EX_I,   16'd2, "slti_exec");
    step(X,      1'b0, 1'b1, C_WB_I,   16'd2, "slti_wb");
    // LW with two MEM wait cycles
    step(X,      1'b0, 1'b1, C_FRDY,   16'd3, "lw_fetch");
    step(3'b101, 1'b0, 1'b1, C_DEC,    16'd3, "lw_dec");
    step(X,      1'b0, 1'b1, C_EX_M,   16'd3, "lw_exec");
    step(X,      1'b0, 1'b0, C_MEM_LW, 16'd3, "lw_mem_w1");
    step(X,      1'b0, 1'b0, C_MEM_LW, 16'd3, "lw_mem_w2");
    step(X,      1'b0, 1'b1, C_MEM_LW, 16'd3, "lw_mem_rdy");
    step(X,      1'b0, 1'b1, C_WB_LW,  16'd3, "lw_wb");
    // BNE with Zero=1 then Zero=0
    step(X,      1'b0, 1'b1, C_FRDY,   16'd4, "bne_z_fetch");
    step(3'b010, 1'b0, 1'b1, C_DEC,    16'd4, "bne_z_dec");
    step(X,      1'b1, 1'b1, C_EX_BZ,  16'd4, "bne_z_exec");
    step(X,      1'b0, 1'b1, C_FRDY,   16'd5, "bne_nz_fetch");
    step(3'b010, 1'b0, 1'b1, C_DEC,    16'd5, "bne_nz_dec");
    step(X,      1'b0, 1'b1, C_EX_BNZ, 16'd5, "bne_nz_exec");
    // illegal opcode 001
    step(X,      1'b0, 1'b1, C_FRDY,   16'd6, "ill_fetch");
    step(3'b001, 1'b0, 1'b1, C_DEC_ILL,16'd6, "ill_dec");
    // SW interrupted by reset in MEM
    step(X,      1'b0, 1'b1, C_FRDY,   16'd6, "sw_fetch");
    step(3'b110, 1'b0, 1'b1, C_DEC,    16'd6, "sw_dec");
    step(X,      1'b0, 1'b1, C_EX_M,   16'd6, "sw_exec");
    step(X,      1'b0, 1'b0, C_MEM_SW, 16'd6, "sw_mem_w1");
    reset_cycle("sw_reset");
    // MemReady on the cycle the counter reaches the limit wins
    step(X,      1'b0, 1'b0, C_FWAIT,  16'd0, "edge_w1");
    step(X,      1'b0, 1'b0, C_FWAIT,  16'd0, "edge_w2");
    step(X,      1'b0, 1'b0, C_FWAIT,  16'd0, "edge_w3");
    step(X,      1'b0, 1'b1, C_FRDY,   16'd0, "edge_rdy");
    step(3'b110, 1'b0, 1'b1, C_DEC,    16'd0, "sw2_dec");
    step(X,      1'b0, 1'b1, C_EX_M,   16'd0, "sw2_exec");
    step(X,      1'b0, 1'b1, C_MEM_SW, 16'd0, "sw2_mem");
    // timeout in FETCH: four wait cycles then sticky FAULT
    for (int i = 0; i < 4; i++) begin
      step(X, 1'b0, 1'b0, C_FWAIT, 16'd1, "to_wait");
    end
    for (int i = 0; i < 3; i++) begin
      step(X, 1'b0, 1'b1, C_FAULT, 16'd1, "fault");
    end
    reset_cycle("fault_reset");
    step(X, 1'b0, 1'b0, C_FWAIT, 16'd0, "post_fault");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge Clock);
    end
    if (exp_q.size() > 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
